// File: rtl/rotl_seq_shifter.sv
// rotl_seq_shifter: multi-cycle rotate-left, one bit position per clock
//   clk/rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready  operand handshake; a and amt are sampled on accept
//   out_valid/out_ready result handshake; y is held until it is consumed
//   busy               high while an operation is in flight or waiting
module rotl_seq_shifter #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:
        if (in_valid) begin
          data_d  = a;
          cnt_d   = amt;
          state_d = (amt == '0) ? DONE : SHIFT;
        end
      SHIFT: begin
        data_d  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        cnt_d   = cnt_q - AMT_W'(1);
        state_d = (cnt_q == AMT_W'(1)) ? DONE : SHIFT;
      end
      DONE:
        state_d = out_ready ? IDLE : DONE;
      default:
        state_d = IDLE;
    endcase
  end
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = data_q;
endmodule

// File: tb/tb_rotl_seq_shifter.sv
// tb_rotl_seq_shifter: scoreboard bench for rotl_seq_shifter against a right-rotate reference
module tb_rotl_seq_shifter;
  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [7:0] a = 0;
  logic [2:0] amt = 0;
  logic out_valid;
  logic out_ready = 0;
  logic [7:0] y;
  logic busy;
  int total = 0;
  int bad = 0;
  typedef struct {logic [7:0] y; int lat;} exp_t;
  exp_t sb[$];

  rotl_seq_shifter #(.WIDTH(8), .AMT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .amt(amt), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rotr_ref(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} >> n;
    return d[7:0];
  endfunction

  task automatic accept(input logic [7:0] av, input logic [2:0] kv);
    exp_t e;
    for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
    in_valid = 1;
    a = av;
    amt = kv;
    e.y = rotr_ref(av, (8 - int'(kv)) % 8);
    e.lat = int'(kv) + 1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom);
      a = 8'($urandom);
      amt = 3'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      total++; if (y !== 8'h00) begin bad++; $display("FAIL reset_y got=%h exp=00", y); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    end
    in_valid = 0;
    out_ready = 0;
    rst_n = 1;
    repeat (3) @(negedge clk);
    total++; if (y !== 8'h00) begin bad++; $display("FAIL post_reset_y got=%h exp=00", y); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic check_result(input string name);
    int lat;
    exp_t e;
    wait_out(lat);
    e = sb.pop_front();
    total++; if (y !== e.y) begin bad++; $display("FAIL %s_y got=%h exp=%h", name, y, e.y); end
    total++; if (lat !== e.lat) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, e.lat); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy got=%b exp=1", name, busy); end
  endtask

  task automatic test_basic();
    accept(8'hB4, 3'd3);
    check_result("basic");
    total++; if (y !== 8'hA5) begin bad++; $display("FAIL basic_const_y got=%h exp=a5", y); end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready_after got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_out_valid_after got=%b exp=0", out_valid); end
  endtask

  task automatic test_boundary();
    accept(8'h3C, 3'd0);
    check_result("amt0");
    total++; if (y !== 8'h3C) begin bad++; $display("FAIL amt0_const_y got=%h exp=3c", y); end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    accept(8'h01, 3'd7);
    check_result("amt7");
    total++; if (y !== 8'h80) begin bad++; $display("FAIL amt7_const_y got=%h exp=80", y); end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_backpressure();
    accept(8'h81, 3'd1);
    check_result("bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1;
      a = 8'hFF;
      amt = 3'd2;
      @(negedge clk);
      total++; if (y !== 8'h03) begin bad++; $display("FAIL bp_hold_y got=%h exp=03", y); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_out_valid got=%b exp=1", out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_in_ready got=%b exp=0", in_ready); end
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_consumed_out_valid got=%b exp=0", out_valid); end
    total++; if (y !== 8'h03) begin bad++; $display("FAIL bp_consumed_y got=%h exp=03", y); end
  endtask

  task automatic test_reset_mid();
    accept(8'hF0, 3'd6);
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    void'(sb.pop_front());
    total++; if (y !== 8'h00) begin bad++; $display("FAIL mid_reset_y got=%h exp=00", y); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_in_ready got=%b exp=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    accept(8'h12, 3'd2);
    check_result("after_reset");
    total++; if (y !== 8'h48) begin bad++; $display("FAIL after_reset_const_y got=%h exp=48", y); end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1;
    for (int i = 0; i < 256; i++)
      for (int k = 0; k < 8; k++) begin
        accept(8'(i), 3'(k));
        check_result("exh");
      end
    @(negedge clk);
    out_ready = 0;
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL sb_empty got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rotl_seq_shifter.md
# rotl_seq_shifter

Sequential rotate-left unit for the shifter experiments. It is the opposite direction of the combinational right rotators. It accepts an operand and rotate amount over a valid/ready handshake and rotates left by one bit position per clock. It presents the result over a valid/ready handshake held until consumed. It serves as the low-area, multi-cycle counterpart to the single-cycle barrel shifters and is checked against them (rotl by k == rotr by WIDTH-k).

## Interface
- WIDTH, 8, operand/result width in bits (power of two, >= 2)
- AMT_W, $clog2(WIDTH), width of rotate amount
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand/amount valid
- in_ready  output  1  unit can accept an operand
- a  input  WIDTH  operand, sampled on accept
- amt  input  AMT_W  left-rotate amount 0..WIDTH-1, sampled on accept
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- y  output  WIDTH  rotated result
- busy  output  1  high in SHIFT or DONE

## Operation
- Registers: state (IDLE, SHIFT, DONE), data[WIDTH-1:0], cnt[AMT_W-1:0].
- in_ready = (state == IDLE). busy = (state != IDLE). out_valid = (state == DONE). y = data at all times.
- IDLE: on in_valid && in_ready, data <= a and cnt <= amt.
  - If amt == 0, next state is DONE.
  - Otherwise, next state is SHIFT.
  - If in_valid is low, there is no change.
- SHIFT: every cycle, data <= {data[WIDTH-2:0], data[WIDTH-1]} and cnt <= cnt - 1.
  - When cnt == 1 in this cycle, next state is DONE.
  - in_valid is ignored.
- DONE: data is held. On out_ready, the next state is IDLE. out_ready outside DONE is ignored.
- No overlap: a new operand is never accepted in the same cycle a result is consumed. in_ready rises the cycle after the DONE handshake.
- amt is interpreted modulo nothing. The full range 0..WIDTH-1 is legal. WIDTH-1 is the longest case.
- Reset (asynchronous, any state including mid-SHIFT) forces:
  - state = IDLE, data = 0, cnt = 0.
  - Therefore out_valid = 0, y = 0, busy = 0, in_ready = 1.
  - An in-flight operation is discarded with no output.

## Timing
- Accept occurs in cycle 0 (in_valid && in_ready at the edge).
- amt == 0: out_valid is high from cycle 1.
- amt = k >= 1: SHIFT occupies cycles 1..k. out_valid is high from cycle k+1.
- Worst case: WIDTH cycles from accept to out_valid.
- out_valid and y are stable until the cycle in which out_ready is sampled high. Both drop in the following cycle.
- Minimum initiation interval: latency + 1 cycle (the IDLE cycle for re-accept).
- All outputs are registered-state decodes. There is no combinational path from inputs to outputs.

## Test plan
- Reset: hold rst_n = 0 with random inputs -> y = 8'h00, out_valid = 0, busy = 0, in_ready = 1. Deasserting with in_valid = 0 keeps all of these values.
- Basic rotate: a = 8'hB4, amt = 3 -> out_valid first high 4 cycles after accept, y = 8'hA5. The bench drives out_ready = 1 and sees in_ready = 1 in the next cycle.
- Boundaries:
  - a = 8'h3C, amt = 0 -> y = 8'h3C, out_valid in cycle 1.
  - a = 8'h01, amt = 7 -> y = 8'h80, out_valid in cycle 8.
- Backpressure: a = 8'h81, amt = 1 with out_ready held low for 5 cycles -> y = 8'h03 stable and out_valid held. in_valid pulses with a = 8'hFF are ignored (in_ready = 0). Result is consumed on the first out_ready.
- Reset mid-operation: a = 8'hF0, amt = 6 with rst_n pulsed low in cycle 3 -> immediately y = 0, out_valid = 0, in_ready = 1. A following a = 8'h12, amt = 2 yields y = 8'h48 with normal timing.
- Exhaustive check: all a in 0..255 and amt in 0..7, back-to-back with out_ready = 1 -> y equals the right-rotate reference model for amount (8 - amt) mod 8. Each latency equals max(amt + 1, 1) cycles.
